// File: rtl/sauria_reg_responder.sv
// sauria_reg_responder
//
// Register-bus responder for the SAURIA window on the Cheshire external register
// port. Decodes the window [BASE_ADDR, BASE_ADDR+WINDOW_SIZE), serves a small
// local control/status file at offsets 0x000-0x0FF and forwards every other
// in-window access to the SAURIA core configuration port through a
// request/acknowledge handshake. Raises a level interrupt on job completion.
//
// Optional feature macro: SAURIA_REG_TIMEOUT_EN
//   When defined, a forwarded access that sees no cfg_ack_i for TIMEOUT_CYCLES
//   cycles is abandoned and answered with error=1. When undefined, forwarded
//   accesses wait indefinitely and no counter exists.
//
// Ports
//   clk_i, rst_i            clock, asynchronous active-high reset
//   reg_valid_i ... wstrb_i register-bus request (held until reg_ready_o)
//   reg_ready_o/rdata/error register-bus response (valid when valid && ready)
//   cfg_req_o ... be_o      forwarded request to the core, held until ack
//   cfg_ack_i, cfg_rdata_i  core acknowledge and read data (same cycle)
//   sauria_start_o          one-cycle job start pulse
//   sauria_done_i           one-cycle job completion pulse
//   irq_o                   level interrupt, DONE & IRQ_EN
//
// Local register map
//   0x00 CTRL   (WO) bit0 START, bit1 CLR_DONE (need strobe byte 0); reads 0
//   0x04 STATUS (RO) bit0 BUSY, bit1 DONE
//   0x08 IRQ_EN (RW) bit0
//   0x0C ID     (RO) ID_VALUE
module sauria_reg_responder #(
  parameter int unsigned           ADDR_WIDTH     = 48,
  parameter int unsigned           DATA_WIDTH     = 32,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR      = 'h4000_0000,
  parameter logic [ADDR_WIDTH-1:0] WINDOW_SIZE    = 'h0500_0000,
  parameter int unsigned           TIMEOUT_CYCLES = 256,
  parameter logic [DATA_WIDTH-1:0] ID_VALUE       = 'h5A0A_0001
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    reg_valid_i,
  input  logic                    reg_write_i,
  input  logic [ADDR_WIDTH-1:0]   reg_addr_i,
  input  logic [DATA_WIDTH-1:0]   reg_wdata_i,
  input  logic [DATA_WIDTH/8-1:0] reg_wstrb_i,
  output logic                    reg_ready_o,
  output logic [DATA_WIDTH-1:0]   reg_rdata_o,
  output logic                    reg_error_o,
  output logic                    cfg_req_o,
  output logic                    cfg_we_o,
  output logic [26:0]             cfg_addr_o,
  output logic [DATA_WIDTH-1:0]   cfg_wdata_o,
  output logic [DATA_WIDTH/8-1:0] cfg_be_o,
  input  logic                    cfg_ack_i,
  input  logic [DATA_WIDTH-1:0]   cfg_rdata_i,
  output logic                    sauria_start_o,
  input  logic                    sauria_done_i,
  output logic                    irq_o
);

  typedef enum logic [1:0] {StIdle, StFwd, StResp} state_e;

  state_e                  state_q;
  logic                    cfg_req_q;
  logic                    cfg_we_q;
  logic [26:0]             cfg_addr_q;
  logic [DATA_WIDTH-1:0]   cfg_wdata_q;
  logic [DATA_WIDTH/8-1:0] cfg_be_q;
  logic [DATA_WIDTH-1:0]   resp_rdata_q;
  logic                    resp_error_q;

  logic busy_q, done_q, irq_en_q, start_q;

`ifdef SAURIA_REG_TIMEOUT_EN
  localparam int unsigned CntWidth = $clog2(TIMEOUT_CYCLES + 1);
  logic [CntWidth-1:0] cnt_q;
`endif

  // ---------------------------------------------------------------------------
  // Address decode
  // ---------------------------------------------------------------------------
  logic [ADDR_WIDTH-1:0] offset;
  logic                  in_window;
  logic                  is_local;
  logic                  fwd_hit;

  // Subtract first and compare the offset so BASE_ADDR+WINDOW_SIZE never overflows.
  assign offset    = reg_addr_i - BASE_ADDR;
  assign in_window = (reg_addr_i >= BASE_ADDR) && (offset < WINDOW_SIZE);
  assign is_local  = (offset[ADDR_WIDTH-1:8] == '0);
  assign fwd_hit   = in_window && !is_local;

  logic [DATA_WIDTH-1:0] loc_rdata;
  logic                  loc_error;

  always_comb begin
    loc_rdata = '0;
    loc_error = 1'b0;
    case (offset[7:0])
      8'h00:   loc_rdata = '0;
      8'h04:   loc_rdata = DATA_WIDTH'({done_q, busy_q});
      8'h08:   loc_rdata = DATA_WIDTH'(irq_en_q);
      8'h0C:   loc_rdata = ID_VALUE;
      default: loc_error = 1'b1;
    endcase
  end

  logic idle_req;
  logic local_wr;
  logic start_req;
  logic clr_req;
  logic irq_en_wr;

  assign idle_req  = (state_q == StIdle) && reg_valid_i;
  assign local_wr  = idle_req && reg_write_i && in_window && is_local;
  assign start_req = local_wr && (offset[7:0] == 8'h00) && reg_wstrb_i[0] && reg_wdata_i[0];
  assign clr_req   = local_wr && (offset[7:0] == 8'h00) && reg_wstrb_i[0] && reg_wdata_i[1];
  assign irq_en_wr = local_wr && (offset[7:0] == 8'h08) && reg_wstrb_i[0];

  // ---------------------------------------------------------------------------
  // Response path: local/error accesses answer combinationally in IDLE,
  // forwarded accesses answer from the registered RESP state.
  // ---------------------------------------------------------------------------
  always_comb begin
    reg_ready_o = 1'b0;
    reg_rdata_o = '0;
    reg_error_o = 1'b0;
    if (rst_i) begin
      // Outputs forced low for the whole reset.
    end else if (state_q == StResp) begin
      reg_ready_o = 1'b1;
      reg_rdata_o = resp_rdata_q;
      reg_error_o = resp_error_q;
    end else if (idle_req && !fwd_hit) begin
      reg_ready_o = 1'b1;
      if (!in_window) begin
        reg_error_o = 1'b1;
      end else begin
        reg_error_o = loc_error;
        if (!reg_write_i && !loc_error) reg_rdata_o = loc_rdata;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Forwarding FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= StIdle;
      cfg_req_q    <= 1'b0;
      cfg_we_q     <= 1'b0;
      cfg_addr_q   <= '0;
      cfg_wdata_q  <= '0;
      cfg_be_q     <= '0;
      resp_rdata_q <= '0;
      resp_error_q <= 1'b0;
`ifdef SAURIA_REG_TIMEOUT_EN
      cnt_q        <= '0;
`endif
    end else begin
      case (state_q)
        StIdle: begin
          if (idle_req && fwd_hit) begin
            state_q     <= StFwd;
            cfg_req_q   <= 1'b1;
            cfg_we_q    <= reg_write_i;
            cfg_addr_q  <= offset[26:0];
            cfg_wdata_q <= reg_wdata_i;
            cfg_be_q    <= reg_wstrb_i;
`ifdef SAURIA_REG_TIMEOUT_EN
            cnt_q       <= '0;
`endif
          end
        end
        StFwd: begin
          // An ack in the timeout cycle still wins.
          if (cfg_ack_i) begin
            state_q      <= StResp;
            cfg_req_q    <= 1'b0;
            resp_rdata_q <= cfg_we_q ? '0 : cfg_rdata_i;
            resp_error_q <= 1'b0;
          end
`ifdef SAURIA_REG_TIMEOUT_EN
          else if (cnt_q == CntWidth'(TIMEOUT_CYCLES)) begin
            state_q      <= StResp;
            cfg_req_q    <= 1'b0;
            resp_rdata_q <= '0;
            resp_error_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
`endif
        end
        StResp: begin
          state_q      <= StIdle;
          resp_rdata_q <= '0;
          resp_error_q <= 1'b0;
        end
        default: begin
          state_q   <= StIdle;
          cfg_req_q <= 1'b0;
        end
      endcase
    end
  end

  assign cfg_req_o   = cfg_req_q;
  assign cfg_we_o    = cfg_we_q;
  assign cfg_addr_o  = cfg_addr_q;
  assign cfg_wdata_o = cfg_wdata_q;
  assign cfg_be_o    = cfg_be_q;

  // ---------------------------------------------------------------------------
  // Local control/status file
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      irq_en_q <= 1'b0;
      start_q  <= 1'b0;
    end else begin
      // START while already busy is dropped.
      start_q <= start_req && !busy_q;
      if (start_req && !busy_q) begin
        busy_q <= 1'b1;
      end else if (sauria_done_i) begin
        busy_q <= 1'b0;
      end
      // Completion beats a coincident CLR_DONE so no job end is lost.
      if (sauria_done_i) begin
        done_q <= 1'b1;
      end else if (clr_req) begin
        done_q <= 1'b0;
      end
      if (irq_en_wr) irq_en_q <= reg_wdata_i[0];
    end
  end

  assign sauria_start_o = start_q;
  assign irq_o          = done_q & irq_en_q;

endmodule

// File: tb/tb_sauria_reg_responder.sv
module tb_sauria_reg_responder;

  localparam int unsigned TO = 16;
  localparam logic [31:0] ID = 32'h5A0A_0001;

  logic        clk = 1'b0;
  logic        rst_i;
  logic        reg_valid_i, reg_write_i;
  logic [47:0] reg_addr_i;
  logic [31:0] reg_wdata_i;
  logic [3:0]  reg_wstrb_i;
  logic        reg_ready_o;
  logic [31:0] reg_rdata_o;
  logic        reg_error_o;
  logic        cfg_req_o, cfg_we_o;
  logic [26:0] cfg_addr_o;
  logic [31:0] cfg_wdata_o;
  logic [3:0]  cfg_be_o;
  logic        cfg_ack_i;
  logic [31:0] cfg_rdata_i;
  logic        sauria_start_o, sauria_done_i, irq_o;

  int checks = 0;
  int errors = 0;
  int start_cnt = 0;

  sauria_reg_responder #(.TIMEOUT_CYCLES(TO)) dut (
    .clk_i          (clk),
    .rst_i          (rst_i),
    .reg_valid_i    (reg_valid_i),
    .reg_write_i    (reg_write_i),
    .reg_addr_i     (reg_addr_i),
    .reg_wdata_i    (reg_wdata_i),
    .reg_wstrb_i    (reg_wstrb_i),
    .reg_ready_o    (reg_ready_o),
    .reg_rdata_o    (reg_rdata_o),
    .reg_error_o    (reg_error_o),
    .cfg_req_o      (cfg_req_o),
    .cfg_we_o       (cfg_we_o),
    .cfg_addr_o     (cfg_addr_o),
    .cfg_wdata_o    (cfg_wdata_o),
    .cfg_be_o       (cfg_be_o),
    .cfg_ack_i      (cfg_ack_i),
    .cfg_rdata_i    (cfg_rdata_i),
    .sauria_start_o (sauria_start_o),
    .sauria_done_i  (sauria_done_i),
    .irq_o          (irq_o)
  );

  always #5 clk = ~clk;

  // start_o is registered; one negedge sample per high cycle.
  always @(negedge clk) if (sauria_start_o) start_cnt++;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout required finish");
    $fatal(1);
  end

  task automatic drive(input logic w, input logic [47:0] a, input logic [31:0] d,
                       input logic [3:0] s);
    @(negedge clk);
    reg_valid_i = 1'b1; reg_write_i = w; reg_addr_i = a; reg_wdata_i = d; reg_wstrb_i = s;
    #1;
  endtask

  task automatic release_bus;
    @(posedge clk); #1;
    reg_valid_i = 1'b0; reg_write_i = 1'b0;
  endtask

  task automatic test_reset;
    rst_i = 1'b1; cfg_ack_i = 1'b0; cfg_rdata_i = '0; sauria_done_i = 1'b0;
    reg_valid_i = 1'b1; reg_write_i = 1'b0; reg_addr_i = 48'h4000_000C;
    reg_wdata_i = '0; reg_wstrb_i = '0;
    repeat (3) @(negedge clk);
    #1;
    checks++; if (reg_ready_o !== 1'b0) begin errors++; $display("FAIL rst_ready: got %b want 0", reg_ready_o); end
    checks++; if (reg_rdata_o !== 32'h0) begin errors++; $display("FAIL rst_rdata: got %h want 0", reg_rdata_o); end
    checks++; if (reg_error_o !== 1'b0) begin errors++; $display("FAIL rst_error: got %b want 0", reg_error_o); end
    checks++; if (cfg_req_o !== 1'b0) begin errors++; $display("FAIL rst_cfg_req: got %b want 0", cfg_req_o); end
    checks++; if (sauria_start_o !== 1'b0) begin errors++; $display("FAIL rst_start: got %b want 0", sauria_start_o); end
    checks++; if (irq_o !== 1'b0) begin errors++; $display("FAIL rst_irq: got %b want 0", irq_o); end
    @(negedge clk);
    rst_i = 1'b0; reg_valid_i = 1'b0;
  endtask

  task automatic test_local_decode;
    drive(1'b0, 48'h4000_000C, '0, '0);
    checks++; if (reg_ready_o !== 1'b1) begin errors++; $display("FAIL id_ready: got %b want 1", reg_ready_o); end
    checks++; if (reg_rdata_o !== ID) begin errors++; $display("FAIL id_rdata: got %h want %h", reg_rdata_o, ID); end
    checks++; if (reg_error_o !== 1'b0) begin errors++; $display("FAIL id_error: got %b want 0", reg_error_o); end
    release_bus;
    drive(1'b0, 48'h3FFF_FFFC, '0, '0);
    checks++; if (reg_ready_o !== 1'b1) begin errors++; $display("FAIL below_ready: got %b want 1", reg_ready_o); end
    checks++; if (reg_error_o !== 1'b1) begin errors++; $display("FAIL below_error: got %b want 1", reg_error_o); end
    checks++; if (reg_rdata_o !== 32'h0) begin errors++; $display("FAIL below_rdata: got %h want 0", reg_rdata_o); end
    release_bus;
    drive(1'b0, 48'h4500_0000, '0, '0);
    checks++; if (reg_error_o !== 1'b1 || reg_ready_o !== 1'b1) begin errors++; $display("FAIL top_edge: got err=%b rdy=%b want 1 1", reg_error_o, reg_ready_o); end
    checks++; if (cfg_req_o !== 1'b0) begin errors++; $display("FAIL top_edge_fwd: got %b want 0", cfg_req_o); end
    release_bus;
    drive(1'b0, 48'h4000_0010, '0, '0);
    checks++; if (reg_error_o !== 1'b1 || reg_rdata_o !== 32'h0) begin errors++; $display("FAIL hole_read: got err=%b rdata=%h want 1 0", reg_error_o, reg_rdata_o); end
    release_bus;
    drive(1'b1, 48'h4000_000C, 32'hFFFF_FFFF, 4'hF);
    checks++; if (reg_error_o !== 1'b0 || reg_ready_o !== 1'b1) begin errors++; $display("FAIL ro_write: got err=%b rdy=%b want 0 1", reg_error_o, reg_ready_o); end
    release_bus;
    drive(1'b0, 48'h4000_000C, '0, '0);
    checks++; if (reg_rdata_o !== ID) begin errors++; $display("FAIL ro_kept: got %h want %h", reg_rdata_o, ID); end
    release_bus;
  endtask

  task automatic test_start_done;
    drive(1'b1, 48'h4000_0008, 32'h1, 4'h1);
    checks++; if (reg_error_o !== 1'b0 || reg_ready_o !== 1'b1) begin errors++; $display("FAIL irqen_wr: got err=%b rdy=%b want 0 1", reg_error_o, reg_ready_o); end
    release_bus;
    drive(1'b0, 48'h4000_0008, '0, '0);
    checks++; if (reg_rdata_o !== 32'h1) begin errors++; $display("FAIL irqen_rd: got %h want 1", reg_rdata_o); end
    release_bus;
    drive(1'b1, 48'h4000_0000, 32'h1, 4'h1);
    checks++; if (sauria_start_o !== 1'b0) begin errors++; $display("FAIL start_early: got %b want 0", sauria_start_o); end
    release_bus;
    checks++; if (sauria_start_o !== 1'b1) begin errors++; $display("FAIL start_pulse: got %b want 1", sauria_start_o); end
    @(posedge clk); #1;
    checks++; if (sauria_start_o !== 1'b0) begin errors++; $display("FAIL start_len: got %b want 0", sauria_start_o); end
    drive(1'b0, 48'h4000_0004, '0, '0);
    checks++; if (reg_rdata_o !== 32'h1) begin errors++; $display("FAIL status_busy: got %h want 1", reg_rdata_o); end
    release_bus;
    @(negedge clk); sauria_done_i = 1'b1;
    @(posedge clk); #1; sauria_done_i = 1'b0;
    checks++; if (irq_o !== 1'b1) begin errors++; $display("FAIL irq_set: got %b want 1", irq_o); end
    drive(1'b0, 48'h4000_0004, '0, '0);
    checks++; if (reg_rdata_o !== 32'h2) begin errors++; $display("FAIL status_done: got %h want 2", reg_rdata_o); end
    release_bus;
    drive(1'b1, 48'h4000_0000, 32'h2, 4'h1);
    release_bus;
    checks++; if (irq_o !== 1'b0) begin errors++; $display("FAIL irq_clr: got %b want 0", irq_o); end
    drive(1'b0, 48'h4000_0004, '0, '0);
    checks++; if (reg_rdata_o !== 32'h0) begin errors++; $display("FAIL status_clr: got %h want 0", reg_rdata_o); end
    release_bus;
  endtask

  task automatic test_start_busy;
    int base;
    base = start_cnt;
    drive(1'b1, 48'h4000_0000, 32'h1, 4'h0);
    release_bus;
    repeat (2) @(posedge clk);
    checks++; if (start_cnt != base) begin errors++; $display("FAIL start_nostrb: got %0d pulses want 0", start_cnt - base); end
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 48'h4000_0000, 32'h1, 4'h1);
      release_bus;
    end
    repeat (3) @(posedge clk);
    checks++; if (start_cnt - base != 1) begin errors++; $display("FAIL start_busy: got %0d pulses want 1", start_cnt - base); end
    // Completion together with CLR_DONE: DONE must survive.
    drive(1'b1, 48'h4000_0000, 32'h2, 4'h1);
    sauria_done_i = 1'b1;
    release_bus;
    sauria_done_i = 1'b0;
    drive(1'b0, 48'h4000_0004, '0, '0);
    checks++; if (reg_rdata_o !== 32'h2) begin errors++; $display("FAIL done_vs_clr: got %h want 2", reg_rdata_o); end
    release_bus;
    drive(1'b1, 48'h4000_0000, 32'h2, 4'h1);
    release_bus;
  endtask

  task automatic test_fwd_read;
    drive(1'b0, 48'h4000_0200, '0, '0);
    checks++; if (reg_ready_o !== 1'b0) begin errors++; $display("FAIL fwd_rd_t0: got %b want 0", reg_ready_o); end
    @(posedge clk); #1;
    checks++; if (cfg_req_o !== 1'b1 || cfg_addr_o !== 27'h200 || cfg_we_o !== 1'b0) begin errors++; $display("FAIL fwd_rd_req: got req=%b addr=%h we=%b want 1 200 0", cfg_req_o, cfg_addr_o, cfg_we_o); end
    @(posedge clk); #1;
    checks++; if (cfg_req_o !== 1'b1 || reg_ready_o !== 1'b0) begin errors++; $display("FAIL fwd_rd_wait: got req=%b rdy=%b want 1 0", cfg_req_o, reg_ready_o); end
    @(posedge clk); #1;
    cfg_ack_i = 1'b1; cfg_rdata_i = 32'hDEAD_BEEF; #1;
    checks++; if (reg_ready_o !== 1'b0) begin errors++; $display("FAIL fwd_rd_t3: got %b want 0", reg_ready_o); end
    @(posedge clk); #1;
    cfg_ack_i = 1'b0; cfg_rdata_i = '0; #1;
    checks++; if (reg_ready_o !== 1'b1 || reg_rdata_o !== 32'hDEAD_BEEF || reg_error_o !== 1'b0) begin errors++; $display("FAIL fwd_rd_resp: got rdy=%b rdata=%h err=%b want 1 deadbeef 0", reg_ready_o, reg_rdata_o, reg_error_o); end
    checks++; if (cfg_req_o !== 1'b0) begin errors++; $display("FAIL fwd_rd_drop: got %b want 0", cfg_req_o); end
    release_bus;
    checks++; if (reg_ready_o !== 1'b0) begin errors++; $display("FAIL fwd_rd_idle: got %b want 0", reg_ready_o); end
  endtask

  task automatic test_fwd_write_reset;
    drive(1'b1, 48'h4000_0100, 32'h1234_5678, 4'h3);
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      checks++; if (cfg_req_o !== 1'b1 || cfg_we_o !== 1'b1 || cfg_be_o !== 4'h3 || cfg_addr_o !== 27'h100 || cfg_wdata_o !== 32'h1234_5678) begin errors++; $display("FAIL fwd_wr_hold%0d: got req=%b we=%b be=%h addr=%h wd=%h want 1 1 3 100 12345678", i, cfg_req_o, cfg_we_o, cfg_be_o, cfg_addr_o, cfg_wdata_o); end
    end
    #2; rst_i = 1'b1; #1;
    checks++; if (cfg_req_o !== 1'b0) begin errors++; $display("FAIL fwd_rst_drop: got %b want 0", cfg_req_o); end
    @(negedge clk); rst_i = 1'b0; reg_valid_i = 1'b0;
    @(negedge clk); cfg_ack_i = 1'b1; #1;
    checks++; if (reg_ready_o !== 1'b0 || cfg_req_o !== 1'b0) begin errors++; $display("FAIL stray_ack: got rdy=%b req=%b want 0 0", reg_ready_o, cfg_req_o); end
    @(negedge clk); cfg_ack_i = 1'b0;
    @(posedge clk); #1;
    checks++; if (reg_ready_o !== 1'b0) begin errors++; $display("FAIL stray_ack_resp: got %b want 0", reg_ready_o); end
    drive(1'b0, 48'h4000_0008, '0, '0);
    checks++; if (reg_ready_o !== 1'b1 || reg_rdata_o !== 32'h0) begin errors++; $display("FAIL rst_irqen: got rdy=%b rdata=%h want 1 0", reg_ready_o, reg_rdata_o); end
    release_bus;
  endtask

  task automatic test_back_to_back;
    drive(1'b1, 48'h4000_0104, 32'hCAFE_0001, 4'hF);
    @(posedge clk); #1;
    cfg_ack_i = 1'b1; cfg_rdata_i = 32'h1111_1111;
    @(posedge clk); #1;
    cfg_ack_i = 1'b0; cfg_rdata_i = '0; #1;
    checks++; if (reg_ready_o !== 1'b1 || reg_rdata_o !== 32'h0 || reg_error_o !== 1'b0) begin errors++; $display("FAIL fwd_wr_min: got rdy=%b rdata=%h err=%b want 1 0 0", reg_ready_o, reg_rdata_o, reg_error_o); end
    release_bus;
    drive(1'b0, 48'h4000_0300, '0, '0);
    @(posedge clk); #1;
    cfg_ack_i = 1'b1; cfg_rdata_i = 32'hA5A5_0F0F;
    @(posedge clk); #1;
    cfg_ack_i = 1'b0; cfg_rdata_i = '0;
    reg_addr_i = 48'h4000_000C; #1;
    checks++; if (reg_ready_o !== 1'b1 || reg_rdata_o !== 32'hA5A5_0F0F) begin errors++; $display("FAIL b2b_first: got rdy=%b rdata=%h want 1 a5a50f0f", reg_ready_o, reg_rdata_o); end
    @(posedge clk); #1;
    checks++; if (reg_ready_o !== 1'b1 || reg_rdata_o !== ID) begin errors++; $display("FAIL b2b_second: got rdy=%b rdata=%h want 1 %h", reg_ready_o, reg_rdata_o, ID); end
    release_bus;
  endtask

`ifdef SAURIA_REG_TIMEOUT_EN
  task automatic test_timeout;
    int n;
    drive(1'b0, 48'h4000_0400, '0, '0);
    @(posedge clk); #1;
    checks++; if (cfg_req_o !== 1'b1) begin errors++; $display("FAIL to_req: got %b want 1", cfg_req_o); end
    n = 0;
    while (reg_ready_o !== 1'b1 && n < int'(TO) + 10) begin
      @(posedge clk); #1;
      n++;
    end
    checks++; if (n != int'(TO) + 1) begin errors++; $display("FAIL to_latency: got %0d want %0d", n, TO + 1); end
    checks++; if (reg_error_o !== 1'b1 || reg_rdata_o !== 32'h0 || cfg_req_o !== 1'b0) begin errors++; $display("FAIL to_resp: got err=%b rdata=%h req=%b want 1 0 0", reg_error_o, reg_rdata_o, cfg_req_o); end
    release_bus;
    cfg_ack_i = 1'b1;
    @(posedge clk); #1;
    cfg_ack_i = 1'b0;
    checks++; if (reg_ready_o !== 1'b0) begin errors++; $display("FAIL to_late_ack: got %b want 0", reg_ready_o); end
    drive(1'b0, 48'h4000_0400, '0, '0);
    @(posedge clk); #1;
    cfg_ack_i = 1'b1; cfg_rdata_i = 32'h0BAD_F00D;
    @(posedge clk); #1;
    cfg_ack_i = 1'b0; cfg_rdata_i = '0;
    checks++; if (reg_ready_o !== 1'b1 || reg_error_o !== 1'b0 || reg_rdata_o !== 32'h0BAD_F00D) begin errors++; $display("FAIL to_next: got rdy=%b err=%b rdata=%h want 1 0 0badf00d", reg_ready_o, reg_error_o, reg_rdata_o); end
    release_bus;
  endtask
`endif

  initial begin
    test_reset();
    test_local_decode();
    test_start_done();
    test_start_busy();
    test_fwd_read();
    test_back_to_back();
`ifdef SAURIA_REG_TIMEOUT_EN
    test_timeout();
`endif
    test_fwd_write_reset();
    repeat (2) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
